// File: rtl/harris_pkg.sv
// Shared state encoding and width helpers for the Harris corner score stream.
package harris_pkg;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_MUL,
    ST_SUB,
    ST_OUT
  } harris_state_t;

  // Window sums of GW x GW products over win*win samples.
  function automatic int acc_w(input int gw, input int win);
    return 2 * gw + $clog2(win * win);
  endfunction

  // Sxx*Syy - Sxy*Sxy needs one bit beyond a single product.
  function automatic int det_w(input int aw);
    return 2 * aw + 1;
  endfunction

  // k_num*trace^2 with trace = aw+1 bits, plus headroom for the final subtraction.
  function automatic int r_w(input int aw, input int k_num);
    return 2 * (aw + 1) + $clog2(k_num + 1) + 1;
  endfunction

endpackage

// File: rtl/harris_mac.sv
// Clearable signed multiply-accumulate: acc += a*b when en, acc = 0 when clr.
module harris_mac
  import harris_pkg::*;
#(
  parameter int GW = 16,
  parameter int AW = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [GW-1:0] a,
  input  logic [GW-1:0] b,
  output logic [AW-1:0] acc
);

  logic signed [AW-1:0] prod;

  assign prod = AW'($signed(a)) * AW'($signed(b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod;
  end

endmodule

// File: rtl/harris_score_stream.sv
// Streaming Harris score: R = det(M) - k*trace(M)^2 per WIN*WIN gradient window.
// Define HARRIS_THRESH_EN to add the thresh input and registered corner flag.
module harris_score_stream
  import harris_pkg::*;
#(
  parameter int GW      = 16,
  parameter int WIN     = 4,
  parameter int K_NUM   = 5,
  parameter int K_SHIFT = 7,
  parameter int RW      = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [GW-1:0] gx,
  input  logic [GW-1:0] gy,
`ifdef HARRIS_THRESH_EN
  input  logic [RW-1:0] thresh,
  output logic          corner,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] r_score
);

  localparam int AW   = acc_w(GW, WIN);
  localparam int TW   = AW + 1;
  localparam int DW   = det_w(AW);
  localparam int RFW  = r_w(AW, K_NUM);
  localparam int NS   = WIN * WIN;
  localparam int CNTW = $clog2(NS + 1);
  localparam int CW   = (RFW > RW) ? RFW : RW;

  harris_state_t state, state_nxt;
  logic [CNTW-1:0] cnt;
  logic accept, last, acc_clr;
  logic signed [AW-1:0]  sxx, sxy, syy;
  logic signed [DW-1:0]  det_p1;
  logic signed [TW-1:0]  trace_p1;
  logic signed [RFW-1:0] ktt_p1, r_full_p1;
  logic signed [RW-1:0]  r_sat_p1;

  function automatic logic signed [RW-1:0] sat_rw(input logic signed [RFW-1:0] v);
    logic signed [CW-1:0] ve, hi, lo;
    ve = CW'(v);
    hi = CW'({1'b0, {(RW-1){1'b1}}});
    lo = CW'($signed({1'b1, {(RW-1){1'b0}}}));
    if (ve > hi)      return hi[RW-1:0];
    else if (ve < lo) return lo[RW-1:0];
    else              return ve[RW-1:0];
  endfunction

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CNTW'(NS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_clr   = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && last) state_nxt = ST_MUL;
      end
      ST_MUL: state_nxt = ST_SUB;
      ST_SUB: state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_ACC;
          acc_clr   = 1'b1;
        end
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (acc_clr) cnt <= '0;
    else if (accept)  cnt <= last ? '0 : cnt + CNTW'(1);
  end

  harris_mac #(.GW(GW), .AW(AW)) u_mac_xx (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(accept), .a(gx), .b(gx), .acc(sxx)
  );
  harris_mac #(.GW(GW), .AW(AW)) u_mac_xy (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(accept), .a(gx), .b(gy), .acc(sxy)
  );
  harris_mac #(.GW(GW), .AW(AW)) u_mac_yy (
    .clk(clk), .rst_n(rst_n), .clr(acc_clr), .en(accept), .a(gy), .b(gy), .acc(syy)
  );

  // Stage p1: determinant and trace of the structure tensor
  always_ff @(posedge clk) begin
    if (state == ST_MUL) begin
      det_p1   <= DW'(sxx) * DW'(syy) - DW'(sxy) * DW'(sxy);
      trace_p1 <= TW'(sxx) + TW'(syy);
    end
  end

  // Stage p2: response with floor shift for k, then saturation to RW
  always_comb begin
    ktt_p1    = RFW'(K_NUM) * RFW'(trace_p1) * RFW'(trace_p1);
    r_full_p1 = RFW'(det_p1) - (ktt_p1 >>> K_SHIFT);
    r_sat_p1  = sat_rw(r_full_p1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score <= '0;
`ifdef HARRIS_THRESH_EN
      corner  <= 1'b0;
`endif
    end else if (state == ST_SUB) begin
      r_score <= r_sat_p1;
`ifdef HARRIS_THRESH_EN
      corner  <= (r_sat_p1 > $signed(thresh));
`endif
    end
  end

endmodule

// File: tb/tb_harris_score_stream.sv
// Directed scoreboard bench for harris_score_stream (default parameters).
module tb_harris_score_stream;

  localparam int GW = 16;
  localparam int RW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [GW-1:0] gx;
  logic [GW-1:0] gy;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] r_score;
`ifdef HARRIS_THRESH_EN
  logic [RW-1:0] thresh;
  logic          corner;
`endif

  int errors = 0;
  int checks = 0;
  logic signed [RW-1:0] exp_q[$];
  logic                 exp_c_q[$];

  always #5 clk = ~clk;

  harris_score_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .gx       (gx),
    .gy       (gy),
`ifdef HARRIS_THRESH_EN
    .thresh   (thresh),
    .corner   (corner),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r_score  (r_score)
  );

  task automatic check(input string tag, input logic signed [RW-1:0] obs,
                       input logic signed [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int x, input int y, input bit gaps);
    int g;
    if (gaps) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    gx = GW'(x);
    gy = GW'(y);
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_ready observed=0 expected=1");
    end
    @(posedge clk);
  endtask

  task automatic window(input int n1, input int x1, input int y1,
                        input int n2, input int x2, input int y2,
                        input bit gaps, input logic signed [RW-1:0] er, input string tag);
    exp_q.push_back(er);
    exp_c_q.push_back(er > 50);
    for (int i = 0; i < n1; i++) send(x1, y1, gaps);
    for (int i = 0; i < n2; i++) send(x2, y2, gaps);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat3"}, out_valid, 1);
  endtask

  task automatic collect(input string tag);
    int g;
    logic signed [RW-1:0] er;
    logic ec;
    g = 0;
    while (!out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20 || exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_out observed=%0d expected=1 (queue %0d)", tag, out_valid, exp_q.size());
    end else begin
      er = exp_q.pop_front();
      ec = exp_c_q.pop_front();
      check({tag, "_r"}, r_score, er);
`ifdef HARRIS_THRESH_EN
      check({tag, "_corner"}, corner, ec);
`endif
      check({tag, "_inrdy"}, in_ready, 0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_done"}, out_valid, 0);
    end
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    gx        = '0;
    gy        = '0;
`ifdef HARRIS_THRESH_EN
    thresh    = RW'(50);
`endif
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_r_score", r_score, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    window(16, 0, 0, 0, 0, 0, 1'b0, 0, "zero");
    collect("zero");

    window(16, 1, 0, 0, 0, 0, 1'b0, -10, "gx1");
    collect("gx1");

    window(16, 2, 2, 0, 0, 0, 1'b0, -640, "gx2gy2");
    collect("gx2gy2");

    window(8, 1, 0, 8, 0, 1, 1'b1, 54, "split");
    collect("split");

    window(16, 1, -1, 0, 0, 0, 1'b0, -40, "negxy");
    collect("negxy");

    // Backpressure: score must hold while a rogue sample is offered
    window(16, 1, 0, 0, 0, 0, 1'b0, -10, "bp");
    in_valid = 1'b1;
    gx = GW'(3);
    gy = GW'(3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_r", r_score, -10);
      check("bp_hold_inrdy", in_ready, 0);
    end
    collect("bp");
    window(16, 1, 1, 0, 0, 0, 1'b0, -40, "after_bp");
    collect("after_bp");

    // Reset in the middle of a window
    for (int i = 0; i < 9; i++) send(7, 3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_r", r_score, 0);
    check("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_spurious", seen, 0);
    window(16, 1, 0, 0, 0, 0, 1'b0, -10, "postrst");
    collect("postrst");

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
